// File: rtl/object_detect_pkg.sv
// rtl/object_detect_pkg.sv - shared state encoding, default sizes and width helper for the object detector
package object_detect_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    DETECTED = 2'd2
  } state_e;

  localparam int DEF_PIX_W    = 8;
  localparam int DEF_MAX_COLS = 640;
  localparam int DEF_MAX_ROWS = 480;

  // Index width for a counter covering 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/object_detection_core_run_length_qualifier.sv
// rtl/object_detection_core_run_length_qualifier.sv - per-pixel hit test, run counter and line qualification
module run_length_qualifier
  import object_detect_pkg::*;
#(
  parameter int PIX_W   = DEF_PIX_W,
  parameter int COL_W   = 10,
  parameter int MIN_RUN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             restart,
  input  logic             eol,
  input  logic [PIX_W-1:0] pix_data,
  input  logic [PIX_W-1:0] thresh,
  input  logic             polarity,
  input  logic [COL_W-1:0] col,
  output logic             line_qualified,
  output logic [COL_W-1:0] qual_col
);

  localparam int RUN_W = idx_width(MIN_RUN + 1);

  logic [RUN_W-1:0] run;
  logic [COL_W-1:0] run_start;
  logic             line_hit;
  logic [COL_W-1:0] hit_col;

  logic [RUN_W-1:0] run_prev;
  logic [RUN_W-1:0] run_next;
  logic             hit_prev;
  logic [COL_W-1:0] hit_col_prev;
  logic [COL_W-1:0] start_now;
  logic             hit;

  // A restarting sof pixel sees a clean line, so the current pixel is judged against zeroed history.
  always_comb begin
    run_prev     = restart ? '0 : run;
    hit_prev     = restart ? 1'b0 : line_hit;
    hit_col_prev = restart ? '0 : hit_col;
    hit          = polarity ? (pix_data < thresh) : (pix_data >= thresh);
    start_now    = (run_prev == '0) ? col : run_start;
    run_next     = '0;
    if (hit) begin
      run_next = (run_prev >= RUN_W'(MIN_RUN)) ? RUN_W'(MIN_RUN) : run_prev + RUN_W'(1);
    end
    line_qualified = hit_prev | (hit && (run_next == RUN_W'(MIN_RUN)));
    qual_col       = hit_prev ? hit_col_prev : start_now;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run       <= '0;
      run_start <= '0;
      line_hit  <= 1'b0;
      hit_col   <= '0;
    end else if (pix_en) begin
      if (eol) begin
        run      <= '0;
        line_hit <= 1'b0;
      end else begin
        run      <= run_next;
        line_hit <= line_qualified;
      end
      run_start <= start_now;
      hit_col   <= qual_col;
    end
  end

endmodule

// File: rtl/object_detection_core.sv
// rtl/object_detection_core.sv - streaming detector: frame FSM, col/row/line counters and registered results
module object_detection_core
  import object_detect_pkg::*;
#(
  parameter int PIX_W     = DEF_PIX_W,
  parameter int MAX_COLS  = DEF_MAX_COLS,
  parameter int MAX_ROWS  = DEF_MAX_ROWS,
  parameter int MIN_RUN   = 3,
  parameter int MIN_LINES = 2,
  localparam int COL_W    = idx_width(MAX_COLS),
  localparam int ROW_W    = idx_width(MAX_ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             sof,
  input  logic             eol,
  input  logic             eof,
  input  logic [PIX_W-1:0] thresh,
  input  logic             polarity,
  output logic             object_detected,
  output logic             detect_pulse,
  output logic [COL_W-1:0] obj_col,
  output logic [ROW_W-1:0] obj_row,
  output logic             frame_done,
  output logic             busy
);

  localparam int LC_W = idx_width(MIN_LINES + 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_SCAN = SCAN;
  localparam logic [1:0] S_DET  = DETECTED;

  logic [1:0]       state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [LC_W-1:0]  line_cnt;

  logic             accept;
  logic             restart;
  logic [1:0]       state_cur;
  logic [1:0]       state_next;
  logic [COL_W-1:0] col_cur;
  logic [ROW_W-1:0] row_cur;
  logic [LC_W-1:0]  lc_cur;
  logic [LC_W-1:0]  lc_next;
  logic             detect;
  logic             line_qualified;
  logic [COL_W-1:0] qual_col;

  run_length_qualifier #(
    .PIX_W   (PIX_W),
    .COL_W   (COL_W),
    .MIN_RUN (MIN_RUN)
  ) u_rlq (
    .clk            (clk),
    .rst            (rst),
    .pix_en         (accept),
    .restart        (restart),
    .eol            (eol),
    .pix_data       (pix_data),
    .thresh         (thresh),
    .polarity       (polarity),
    .col            (col_cur),
    .line_qualified (line_qualified),
    .qual_col       (qual_col)
  );

  // sof is honoured in every state; it rewinds the frame position before the pixel is evaluated.
  always_comb begin
    accept    = pix_valid && (sof || (state != S_IDLE));
    restart   = pix_valid && sof;
    state_cur = sof ? S_SCAN : state;
    col_cur   = sof ? '0 : col;
    row_cur   = sof ? '0 : row;
    lc_cur    = sof ? '0 : line_cnt;
    lc_next   = '0;
    if (line_qualified) begin
      lc_next = (lc_cur >= LC_W'(MIN_LINES)) ? LC_W'(MIN_LINES) : lc_cur + LC_W'(1);
    end
    detect = accept && eol && line_qualified &&
             (lc_next == LC_W'(MIN_LINES)) && (state_cur == S_SCAN);
    state_next = state;
    if (accept) begin
      if (eof)         state_next = S_IDLE;
      else if (detect) state_next = S_DET;
      else             state_next = state_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_IDLE;
      col             <= '0;
      row             <= '0;
      line_cnt        <= '0;
      object_detected <= 1'b0;
      detect_pulse    <= 1'b0;
      obj_col         <= '0;
      obj_row         <= '0;
      frame_done      <= 1'b0;
      busy            <= 1'b0;
    end else begin
      detect_pulse <= detect;
      frame_done   <= accept && eof;
      if (accept) begin
        state <= state_next;
        busy  <= (state_next != S_IDLE);
        if (eol) begin
          col      <= '0;
          row      <= (row_cur == ROW_W'(MAX_ROWS - 1)) ? row_cur : row_cur + ROW_W'(1);
          line_cnt <= lc_next;
        end else begin
          col      <= (col_cur == COL_W'(MAX_COLS - 1)) ? col_cur : col_cur + COL_W'(1);
          row      <= row_cur;
          line_cnt <= lc_cur;
        end
        object_detected <= detect | (object_detected & ~sof);
        if (detect) begin
          obj_col <= qual_col;
          obj_row <= row_cur;
        end
      end
    end
  end

endmodule

// File: tb/tb_object_detection_core.sv
// tb/tb_object_detection_core.sv - directed table-driven bench for object_detection_core
module tb_object_detection_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic       sof = 1'b0;
  logic       eol = 1'b0;
  logic       eof = 1'b0;
  logic [7:0] thresh = 8'h80;
  logic       polarity = 1'b0;
  logic       object_detected;
  logic       detect_pulse;
  logic [9:0] obj_col;
  logic [8:0] obj_row;
  logic       frame_done;
  logic       busy;

  int tests = 0;
  int fails = 0;

  object_detection_core #(
    .PIX_W(8), .MAX_COLS(640), .MAX_ROWS(480), .MIN_RUN(3), .MIN_LINES(2)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
    .sof(sof), .eol(eol), .eof(eof), .thresh(thresh), .polarity(polarity),
    .object_detected(object_detected), .detect_pulse(detect_pulse),
    .obj_col(obj_col), .obj_row(obj_row), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0][63:0] ln;
    int               nl;
    logic             pol;
    logic [7:0]       th;
    logic             det;
    int               dl;
    int               ecol;
    int               erow;
  } vec_t;

  localparam int NV = 6;
  localparam logic [63:0] QLINE = 64'h00_10_80_90_A0_00_00_00;
  localparam logic [63:0] T5LINE = 64'h00_00_00_00_80_80_80_00;

  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic px(input logic v, input logic [7:0] d, input logic s, input logic e, input logic f);
    pix_valid = v; pix_data = d; sof = s; eol = e; eof = f;
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input logic [63:0] bits, input logic s, input logic f,
                           output logic saw_pulse, output logic saw_fd);
    saw_pulse = 1'b0;
    saw_fd    = 1'b0;
    for (int c = 0; c < 8; c++) begin
      px(1'b1, bits[63-8*c -: 8], s && (c == 0), c == 7, f && (c == 7));
      saw_pulse |= detect_pulse;
      saw_fd    |= frame_done;
    end
  endtask

  initial begin
    logic [63:0] bits;
    logic        ep, ef, eo, eb, sp, sf;
    int          last_col, last_row;

    tbl[0] = '{ln: {64'h0, QLINE, QLINE, QLINE}, nl: 3, pol: 1'b0, th: 8'h80,
               det: 1'b1, dl: 1, ecol: 2, erow: 1};
    tbl[1] = '{ln: {64'h0, 64'h0, 64'h40_10_20_00_00_00_00_00, 64'h40_10_20_00_00_00_00_00},
               nl: 2, pol: 1'b0, th: 8'h80, det: 1'b0, dl: 99, ecol: 0, erow: 0};
    tbl[2] = '{ln: {64'h00_85_90_FF_00_00_00_00, QLINE, 64'h00_00_80_80_00_80_00_00, QLINE},
               nl: 4, pol: 1'b0, th: 8'h80, det: 1'b1, dl: 3, ecol: 1, erow: 3};
    tbl[3] = '{ln: {64'h0, 64'h0, 64'h40_10_20_00_00_00_00_00, 64'h40_10_20_00_00_00_00_00},
               nl: 2, pol: 1'b1, th: 8'h80, det: 1'b1, dl: 1, ecol: 0, erow: 1};
    tbl[4] = '{ln: {64'h0, 64'h0, 64'h00_00_00_00_00_90_FF_80, QLINE},
               nl: 2, pol: 1'b0, th: 8'h80, det: 1'b1, dl: 1, ecol: 5, erow: 1};
    tbl[5] = '{ln: {64'h0, 64'h0, 64'h0, 64'h0},
               nl: 2, pol: 1'b0, th: 8'h00, det: 1'b1, dl: 1, ecol: 0, erow: 1};

    rst = 1'b0;
    px(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    px(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk("reset object_detected", {31'b0, object_detected}, 0);
    chk("reset detect_pulse", {31'b0, detect_pulse}, 0);
    chk("reset obj_col", {22'b0, obj_col}, 0);
    chk("reset obj_row", {23'b0, obj_row}, 0);
    chk("reset frame_done", {31'b0, frame_done}, 0);
    chk("reset busy", {31'b0, busy}, 0);
    rst = 1'b1;
    px(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    last_col = 0;
    last_row = 0;
    for (int i = 0; i < NV; i++) begin
      thresh   = tbl[i].th;
      polarity = tbl[i].pol;
      for (int l = 0; l < tbl[i].nl; l++) begin
        bits = tbl[i].ln[l];
        for (int c = 0; c < 8; c++) begin
          px(1'b1, bits[63-8*c -: 8], (l == 0) && (c == 0), c == 7,
             (l == tbl[i].nl - 1) && (c == 7));
          ep = tbl[i].det && (l == tbl[i].dl) && (c == 7);
          ef = (l == tbl[i].nl - 1) && (c == 7);
          eo = tbl[i].det && ((l > tbl[i].dl) || ((l == tbl[i].dl) && (c == 7)));
          eb = !ef;
          chk($sformatf("v%0d l%0d c%0d detect_pulse", i, l, c), {31'b0, detect_pulse}, {31'b0, ep});
          chk($sformatf("v%0d l%0d c%0d frame_done", i, l, c), {31'b0, frame_done}, {31'b0, ef});
          chk($sformatf("v%0d l%0d c%0d object_detected", i, l, c), {31'b0, object_detected}, {31'b0, eo});
          chk($sformatf("v%0d l%0d c%0d busy", i, l, c), {31'b0, busy}, {31'b0, eb});
          if (ep) begin
            last_col = tbl[i].ecol;
            last_row = tbl[i].erow;
            chk($sformatf("v%0d obj_col", i), {22'b0, obj_col}, last_col);
            chk($sformatf("v%0d obj_row", i), {23'b0, obj_row}, last_row);
          end
        end
      end
      px(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d idle detect_pulse", i), {31'b0, detect_pulse}, 0);
      chk($sformatf("v%0d idle frame_done", i), {31'b0, frame_done}, 0);
      chk($sformatf("v%0d idle object_detected", i), {31'b0, object_detected}, {31'b0, tbl[i].det});
      chk($sformatf("v%0d idle busy", i), {31'b0, busy}, 0);
      chk($sformatf("v%0d idle obj_col", i), {22'b0, obj_col}, last_col);
      chk($sformatf("v%0d idle obj_row", i), {23'b0, obj_row}, last_row);
    end

    // Reset mid-frame after one qualifying line; the following line alone must not detect.
    thresh = 8'h80; polarity = 1'b0;
    send_line(QLINE, 1'b1, 1'b0, sp, sf);
    chk("t4 busy before reset", {31'b0, busy}, 1);
    rst = 1'b0;
    px(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t4 reset object_detected", {31'b0, object_detected}, 0);
    chk("t4 reset obj_col", {22'b0, obj_col}, 0);
    chk("t4 reset obj_row", {23'b0, obj_row}, 0);
    chk("t4 reset busy", {31'b0, busy}, 0);
    rst = 1'b1;
    send_line(QLINE, 1'b0, 1'b0, sp, sf);
    chk("t4 no-sof line pulse", {31'b0, sp}, 0);
    chk("t4 no-sof line busy", {31'b0, busy}, 0);
    send_line(QLINE, 1'b1, 1'b1, sp, sf);
    chk("t4 single line pulse", {31'b0, sp}, 0);
    chk("t4 single line frame_done", {31'b0, frame_done}, 1);
    chk("t4 single line object_detected", {31'b0, object_detected}, 0);
    px(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // sof mid-frame after a detection restarts the frame.
    send_line(QLINE, 1'b1, 1'b0, sp, sf);
    send_line(QLINE, 1'b0, 1'b0, sp, sf);
    chk("t5 first pulse", {31'b0, detect_pulse}, 1);
    px(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t5 pulse one cycle", {31'b0, detect_pulse}, 0);
    chk("t5 object_detected held", {31'b0, object_detected}, 1);
    px(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t5 sof clears object_detected", {31'b0, object_detected}, 0);
    chk("t5 sof keeps obj_col", {22'b0, obj_col}, 2);
    for (int c = 1; c < 8; c++) px(1'b1, 8'h00, 1'b0, c == 7, 1'b0);
    send_line(T5LINE, 1'b0, 1'b0, sp, sf);
    chk("t5 one line no pulse", {31'b0, sp}, 0);
    send_line(T5LINE, 1'b0, 1'b1, sp, sf);
    chk("t5 second pulse", {31'b0, detect_pulse}, 1);
    chk("t5 frame_done", {31'b0, frame_done}, 1);
    chk("t5 obj_col", {22'b0, obj_col}, 4);
    chk("t5 obj_row", {23'b0, obj_row}, 2);
    px(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t5 busy after eof", {31'b0, busy}, 0);
    chk("t5 object_detected after eof", {31'b0, object_detected}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
